obj_tile_fetcher: RTL and testbench
===================================

Name: obj_tile_fetcher

Overview:
- Per-scanline OBJ tile fetch engine: walks the evaluated sprite list (obj_next_list_type entries) for the next line, reads 4bpp bitplane rows from VRAM, and writes packed obj_type slices into the line-renderer tile buffer.
- Writer side of the obj_type buffer consumed by the OBJ pixel shifter; runs during H-blank, started by the PPU timing block.

Parameters:
- MAX_TILES, 34, tile-slice limit per line (time-over threshold).
- LIST_DEPTH, 32, maximum list entries.

Ports:
- clk  in  1  PPU clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: begin fetch for next line
- num_objs  in  6  valid list entries (0..LIST_DEPTH)
- obj_base_addr  in  15  VRAM word base of OBJ tiles
- list_addr  out  5  sprite list read index
- list_data  in  $bits(obj_next_list_type)  list entry, valid 1 cycle after list_addr
- vram_req  out  1  VRAM read request
- vram_addr  out  15  VRAM word address
- vram_ack  in  1  read done; vram_rdata valid this cycle
- vram_rdata  in  16  {plane1 byte, plane0 byte} or {plane3, plane2}
- tile_we  out  1  buffer write strobe
- tile_waddr  out  6  buffer slot
- tile_wdata  out  $bits(obj_type)  packed slice
- tile_count  out  6  slices written this line
- time_over  out  1  sticky: more than MAX_TILES slices needed
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal entry/column counters 0. Reset mid-fetch aborts immediately; no done pulse.
- FSM states: IDLE, LIST_RD, LIST_WAIT, SCAN, FETCH_LO, FETCH_HI, WRITE, FINISH.
- IDLE: on start, clear tile_count, time_over, entry index; busy=1; go LIST_RD, or FINISH if num_objs==0. start while busy is ignored.
- LIST_RD: drive list_addr=entry index; LIST_WAIT: latch list_data; column c=0; go SCAN.
- SCAN: one column per cycle. tile_exist[c] indexes screen column c. If set, go FETCH_LO. Else c++. If c>size_x or c==7 (after checking), entry++; go LIST_RD, or FINISH if entry==num_objs.
- Source column sc = x_flip ? size_x-c : c (3-bit). Tile number: {tile_index[8], tile_index[7:4]+fine_y[5:3], tile_index[3:0]+sc}. Both nibble adds wrap mod 16 with no carry.
- Row address: obj_base_addr + {tile_num,4'b0} + fine_y[2:0], 15-bit wrap. FETCH_HI uses the same address +8.
- VRAM handshake: vram_req and vram_addr are asserted on FETCH_x entry and held stable until the vram_ack cycle. vram_rdata is latched on ack, and req drops the next cycle. Back-to-back requests are allowed. Ack without req is ignored.
- Before fetch, if tile_count==MAX_TILES: set time_over, go FINISH (slice not written).
- WRITE: one cycle, tile_we=1, tile_waddr=tile_count.
  - pixels_0..3 = plane bytes, each bit-reversed when x_flip.
  - x = entry.x + 8*c, 9-bit two's-complement wrap.
  - palette and prior copied from the entry.
  - tile_count++ registered; then c++ and SCAN as above.
- FINISH: done=1 for one cycle, busy=0, go IDLE. tile_count and time_over hold until the next start.
- Latency per slice: 2 + 2×(ack wait) cycles + SCAN cycle.

Test Plan:
- num_objs=0, start -> done 1 cycle later path via FINISH, tile_count=0, no vram_req, no tile_we.
- One entry: x=10, size_x=1, tile_exist=0x03, tile_index=0x012, fine_y=9, base=0x4000, ack after 2 cycles:
  - Expected addrs 0x4221, 0x4229, 0x4231, 0x4239.
  - Expected slices x=10 and x=18.
  - tile_count=2.
- Same entry with x_flip=1 -> first slice fetched from tile 0x023, bytes bit-reversed (0x01→0x80); x=10.
- tile_index=0x0FF, sc=1, fine_y=8 -> tile_num wraps to 0x000 (nibble wrap, bit8 kept). x=-4 with c=1 -> x=4; x=0x1FC stays signed wrap.
- 5 entries × 8 visible columns = 40 slices -> 34 writes, time_over=1, done pulse, no write to slot 34.
- Reset asserted during FETCH_HI with vram_req high -> next cycle vram_req=0, busy=0, tile_we=0. Next start fetches normally.

Source files
------------

// File: rtl/obj_tile_fetcher.sv
// OBJ tile fetch engine: walks the next-line sprite list during H-blank and
// writes 4bpp bitplane slices into the line-renderer OBJ tile buffer.
package obj_pkg;
    typedef struct packed {
        logic [8:0] x;
        logic [5:0] fine_y;
        logic [8:0] tile_index;
        logic [2:0] size_x;
        logic [7:0] tile_exist;
        logic       x_flip;
        logic [3:0] palette;
        logic [1:0] prior;
    } obj_next_list_type;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] pixels_3;
        logic [7:0] pixels_2;
        logic [7:0] pixels_1;
        logic [7:0] pixels_0;
        logic [3:0] palette;
        logic [1:0] prior;
    } obj_type;
endpackage

module obj_tile_fetcher
    import obj_pkg::*;
#(
    parameter int MAX_TILES  = 34,
    parameter int LIST_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [5:0]                    num_objs,
    input  logic [14:0]                   obj_base_addr,
    output logic [4:0]                    list_addr,
    input  logic [$bits(obj_next_list_type)-1:0] list_data,
    output logic                          vram_req,
    output logic [14:0]                   vram_addr,
    input  logic                          vram_ack,
    input  logic [15:0]                   vram_rdata,
    output logic                          tile_we,
    output logic [5:0]                    tile_waddr,
    output logic [$bits(obj_type)-1:0]    tile_wdata,
    output logic [5:0]                    tile_count,
    output logic                          time_over,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [2:0] {
        IDLE, LIST_RD, LIST_WAIT, SCAN, FETCH_LO, FETCH_HI, WRITE, FINISH
    } state_t;

    localparam logic [5:0] MAX_T   = 6'(MAX_TILES);
    localparam logic [5:0] DEPTH_T = 6'(LIST_DEPTH);

    state_t            state_q, state_d;
    logic [5:0]        entry_q, entry_d;
    logic [5:0]        num_q, num_d;
    logic [2:0]        col_q, col_d;
    obj_next_list_type ent_q, ent_d;
    logic [15:0]       plane01_q, plane01_d;
    logic              vram_req_q, vram_req_d;
    logic [14:0]       vram_addr_q, vram_addr_d;
    logic              tile_we_q, tile_we_d;
    logic [5:0]        tile_waddr_q, tile_waddr_d;
    obj_type           tile_wdata_q, tile_wdata_d;
    logic [5:0]        tile_count_q, tile_count_d;
    logic              time_over_q, time_over_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [2:0]  src_col;
    logic [8:0]  tile_num;
    logic [14:0] row_addr;
    logic [5:0]  entry_nxt;
    logic        last_col;

    function automatic logic [7:0] flip8(input logic [7:0] b, input logic f);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return f ? r : b;
    endfunction

    always_comb begin
        src_col  = ent_q.x_flip ? 3'(ent_q.size_x - col_q) : col_q;
        // Nibble adds wrap inside the 16x16 tile grid; bit 8 selects the bank.
        tile_num = {ent_q.tile_index[8],
                    4'(ent_q.tile_index[7:4] + {1'b0, ent_q.fine_y[5:3]}),
                    4'(ent_q.tile_index[3:0] + {1'b0, src_col})};
        row_addr = 15'(obj_base_addr + {2'b0, tile_num, 4'b0}
                       + {12'b0, ent_q.fine_y[2:0]});
        entry_nxt = entry_q + 6'd1;
        last_col  = (col_q >= ent_q.size_x);
    end

    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        num_d        = num_q;
        col_d        = col_q;
        ent_d        = ent_q;
        plane01_d    = plane01_q;
        vram_req_d   = vram_req_q;
        vram_addr_d  = vram_addr_q;
        tile_we_d    = 1'b0;
        tile_waddr_d = tile_waddr_q;
        tile_wdata_d = tile_wdata_q;
        tile_count_d = tile_count_q;
        time_over_d  = time_over_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tile_count_d = '0;
                    time_over_d  = 1'b0;
                    entry_d      = '0;
                    busy_d       = 1'b1;
                    num_d        = (num_objs > DEPTH_T) ? DEPTH_T : num_objs;
                    state_d      = (num_objs == 6'd0) ? FINISH : LIST_RD;
                end
            end
            LIST_RD: state_d = LIST_WAIT;
            LIST_WAIT: begin
                ent_d   = obj_next_list_type'(list_data);
                col_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (ent_q.tile_exist[col_q]) begin
                    if (tile_count_q == MAX_T) begin
                        time_over_d = 1'b1;
                        state_d     = FINISH;
                    end else begin
                        vram_req_d  = 1'b1;
                        vram_addr_d = row_addr;
                        state_d     = FETCH_LO;
                    end
                end else if (last_col) begin
                    entry_d = entry_nxt;
                    state_d = (entry_nxt == num_q) ? FINISH : LIST_RD;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            FETCH_LO: begin
                if (vram_ack) begin
                    plane01_d   = vram_rdata;
                    vram_addr_d = vram_addr_q + 15'd8;
                    state_d     = FETCH_HI;
                end
            end
            FETCH_HI: begin
                if (vram_ack) begin
                    vram_req_d            = 1'b0;
                    tile_we_d             = 1'b1;
                    tile_waddr_d          = tile_count_q;
                    tile_wdata_d.x        = 9'(ent_q.x + {3'b0, col_q, 3'b0});
                    tile_wdata_d.pixels_0 = flip8(plane01_q[7:0], ent_q.x_flip);
                    tile_wdata_d.pixels_1 = flip8(plane01_q[15:8], ent_q.x_flip);
                    tile_wdata_d.pixels_2 = flip8(vram_rdata[7:0], ent_q.x_flip);
                    tile_wdata_d.pixels_3 = flip8(vram_rdata[15:8], ent_q.x_flip);
                    tile_wdata_d.palette  = ent_q.palette;
                    tile_wdata_d.prior    = ent_q.prior;
                    state_d               = WRITE;
                end
            end
            WRITE: begin
                tile_count_d = tile_count_q + 6'd1;
                if (last_col) begin
                    entry_d = entry_nxt;
                    state_d = (entry_nxt == num_q) ? FINISH : LIST_RD;
                end else begin
                    col_d   = col_q + 3'd1;
                    state_d = SCAN;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            entry_q      <= '0;
            num_q        <= '0;
            col_q        <= '0;
            ent_q        <= '0;
            plane01_q    <= '0;
            vram_req_q   <= 1'b0;
            vram_addr_q  <= '0;
            tile_we_q    <= 1'b0;
            tile_waddr_q <= '0;
            tile_wdata_q <= '0;
            tile_count_q <= '0;
            time_over_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            entry_q      <= entry_d;
            num_q        <= num_d;
            col_q        <= col_d;
            ent_q        <= ent_d;
            plane01_q    <= plane01_d;
            vram_req_q   <= vram_req_d;
            vram_addr_q  <= vram_addr_d;
            tile_we_q    <= tile_we_d;
            tile_waddr_q <= tile_waddr_d;
            tile_wdata_q <= tile_wdata_d;
            tile_count_q <= tile_count_d;
            time_over_q  <= time_over_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign list_addr  = entry_q[4:0];
    assign vram_req   = vram_req_q;
    assign vram_addr  = vram_addr_q;
    assign tile_we    = tile_we_q;
    assign tile_waddr = tile_waddr_q;
    assign tile_wdata = tile_wdata_q;
    assign tile_count = tile_count_q;
    assign time_over  = time_over_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_obj_tile_fetcher.sv
// Directed bench for obj_tile_fetcher: sync list RAM, VRAM ack model with
// programmable wait, monitors for buffer writes and acked addresses.
module tb_obj_tile_fetcher;
    import obj_pkg::*;

    logic              clk;
    logic              reset;
    logic              start;
    logic [5:0]        num_objs;
    logic [14:0]       obj_base_addr;
    logic [4:0]        list_addr;
    obj_next_list_type list_data;
    logic              vram_req;
    logic [14:0]       vram_addr;
    logic              vram_ack;
    logic [15:0]       vram_rdata;
    logic              tile_we;
    logic [5:0]        tile_waddr;
    obj_type           tile_wdata;
    logic [5:0]        tile_count;
    logic              time_over;
    logic              busy;
    logic              done;

    obj_tile_fetcher #(.MAX_TILES(34), .LIST_DEPTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .num_objs(num_objs),
        .obj_base_addr(obj_base_addr), .list_addr(list_addr),
        .list_data(list_data), .vram_req(vram_req), .vram_addr(vram_addr),
        .vram_ack(vram_ack), .vram_rdata(vram_rdata), .tile_we(tile_we),
        .tile_waddr(tile_waddr), .tile_wdata(tile_wdata),
        .tile_count(tile_count), .time_over(time_over), .busy(busy),
        .done(done)
    );

    int errors = 0;
    int checks = 0;

    obj_next_list_type list_mem [32];
    obj_type           wr_q [$];
    logic [5:0]        wa_q [$];
    logic [14:0]       aa_q [$];
    int                req_seen;
    int                done_cnt;
    int                ack_wait;
    int                cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) list_data <= list_mem[list_addr];

    // VRAM model: lo byte = addr[7:0], hi byte = addr[7:0] + 0x10
    initial begin
        vram_ack   = 1'b0;
        vram_rdata = '0;
        cnt        = 0;
        forever begin
            @(posedge clk);
            #1;
            if (vram_ack) begin
                vram_ack = 1'b0;
                cnt      = 0;
            end else if (vram_req) begin
                cnt++;
                if (cnt >= ack_wait) begin
                    vram_ack   = 1'b1;
                    vram_rdata = {8'(vram_addr[7:0] + 8'h10), vram_addr[7:0]};
                    aa_q.push_back(vram_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (tile_we) begin
            wr_q.push_back(tile_wdata);
            wa_q.push_back(tile_waddr);
        end
        if (vram_req) req_seen++;
        if (done) done_cnt++;
    end

    function automatic obj_next_list_type mk(
        input logic [8:0] x, input logic [5:0] fy, input logic [8:0] ti,
        input logic [2:0] sx, input logic [7:0] te, input logic fl,
        input logic [3:0] pal, input logic [1:0] pr);
        obj_next_list_type e;
        e.x = x; e.fine_y = fy; e.tile_index = ti; e.size_x = sx;
        e.tile_exist = te; e.x_flip = fl; e.palette = pal; e.prior = pr;
        return e;
    endfunction

    function automatic obj_type mks(
        input logic [8:0] x, input logic [7:0] p0, input logic [7:0] p1,
        input logic [7:0] p2, input logic [7:0] p3,
        input logic [3:0] pal, input logic [1:0] pr);
        obj_type s;
        s.x = x; s.pixels_0 = p0; s.pixels_1 = p1; s.pixels_2 = p2;
        s.pixels_3 = p3; s.palette = pal; s.prior = pr;
        return s;
    endfunction

    task automatic clear_logs();
        wr_q.delete();
        wa_q.delete();
        aa_q.delete();
        req_seen = 0;
        done_cnt = 0;
    endtask

    task automatic run_fetch(input int n, output int cyc);
        @(negedge clk);
        num_objs = 6'(n);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, vram_req, tile_we, time_over} !== 5'b0 ||
            tile_count !== 6'd0 || list_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b req=%b we=%b to=%b cnt=%0d la=%0d want all 0",
                     busy, done, vram_req, tile_we, time_over, tile_count, list_addr);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_empty();
        int cyc;
        clear_logs();
        run_fetch(0, cyc);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL empty_latency: got %0d want 2", cyc);
        end
        checks++;
        if (tile_count !== 6'd0 || req_seen !== 0 || wr_q.size() !== 0) begin
            errors++;
            $display("FAIL empty_activity: got cnt=%0d req=%0d wr=%0d want 0 0 0",
                     tile_count, req_seen, wr_q.size());
        end
        checks++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: got done_cnt=%0d busy=%b want 1 0",
                     done_cnt, busy);
        end
    endtask

    task automatic test_single();
        int cyc;
        logic [14:0] ea [4];
        obj_type e0, e1;
        ea[0] = 15'h4221; ea[1] = 15'h4229; ea[2] = 15'h4231; ea[3] = 15'h4239;
        e0 = mks(9'd10, 8'h21, 8'h31, 8'h29, 8'h39, 4'd5, 2'd2);
        e1 = mks(9'd18, 8'h31, 8'h41, 8'h39, 8'h49, 4'd5, 2'd2);
        list_mem[0] = mk(9'd10, 6'd9, 9'h012, 3'd1, 8'h03, 1'b0, 4'd5, 2'd2);
        obj_base_addr = 15'h4000;
        ack_wait = 2;
        clear_logs();
        run_fetch(1, cyc);
        checks++;
        if (aa_q.size() !== 4) begin
            errors++;
            $display("FAIL single_nreq: got %0d want 4", aa_q.size());
        end
        for (int i = 0; i < 4 && i < aa_q.size(); i++) begin
            checks++;
            if (aa_q[i] !== ea[i]) begin
                errors++;
                $display("FAIL single_addr%0d: got %h want %h", i, aa_q[i], ea[i]);
            end
        end
        checks++;
        if (wr_q.size() !== 2 || tile_count !== 6'd2 || time_over !== 1'b0) begin
            errors++;
            $display("FAIL single_count: got wr=%0d cnt=%0d to=%b want 2 2 0",
                     wr_q.size(), tile_count, time_over);
        end else begin
            checks++;
            if (wr_q[0] !== e0 || wa_q[0] !== 6'd0) begin
                errors++;
                $display("FAIL single_slice0: got %h@%0d want %h@0", wr_q[0], wa_q[0], e0);
            end
            checks++;
            if (wr_q[1] !== e1 || wa_q[1] !== 6'd1) begin
                errors++;
                $display("FAIL single_slice1: got %h@%0d want %h@1", wr_q[1], wa_q[1], e1);
            end
        end
    endtask

    task automatic test_flip();
        int cyc;
        obj_type e0, e1;
        e0 = mks(9'd10, 8'h8C, 8'h82, 8'h9C, 8'h92, 4'd3, 2'd1);
        e1 = mks(9'd18, 8'h84, 8'h8C, 8'h94, 8'h9C, 4'd3, 2'd1);
        list_mem[0] = mk(9'd10, 6'd9, 9'h012, 3'd1, 8'h03, 1'b1, 4'd3, 2'd1);
        obj_base_addr = 15'h4000;
        ack_wait = 3;
        clear_logs();
        run_fetch(1, cyc);
        checks++;
        if (aa_q.size() < 1 || aa_q[0] !== 15'h4231) begin
            errors++;
            $display("FAIL flip_addr0: got %h want 4231", aa_q.size() ? aa_q[0] : 15'h0);
        end
        checks++;
        if (wr_q.size() !== 2) begin
            errors++;
            $display("FAIL flip_count: got %0d want 2", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0] !== e0) begin
                errors++;
                $display("FAIL flip_slice0: got %h want %h", wr_q[0], e0);
            end
            checks++;
            if (wr_q[1] !== e1) begin
                errors++;
                $display("FAIL flip_slice1: got %h want %h", wr_q[1], e1);
            end
        end
    endtask

    task automatic test_wrap();
        int cyc;
        logic [14:0] ea [4];
        obj_type e0, e1;
        ea[0] = 15'h00EC; ea[1] = 15'h00F4; ea[2] = 15'h7FFC; ea[3] = 15'h0004;
        e0 = mks(9'h1FC, 8'hEC, 8'hFC, 8'hF4, 8'h04, 4'd9, 2'd3);
        e1 = mks(9'h004, 8'hFC, 8'h0C, 8'h04, 8'h14, 4'd9, 2'd3);
        list_mem[0] = mk(9'h1FC, 6'd8, 9'h0FF, 3'd1, 8'h03, 1'b0, 4'd9, 2'd3);
        obj_base_addr = 15'h7FFC;
        ack_wait = 1;
        clear_logs();
        run_fetch(1, cyc);
        checks++;
        if (aa_q.size() !== 4) begin
            errors++;
            $display("FAIL wrap_nreq: got %0d want 4", aa_q.size());
        end
        for (int i = 0; i < 4 && i < aa_q.size(); i++) begin
            checks++;
            if (aa_q[i] !== ea[i]) begin
                errors++;
                $display("FAIL wrap_addr%0d: got %h want %h", i, aa_q[i], ea[i]);
            end
        end
        checks++;
        if (wr_q.size() !== 2) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 2", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0] !== e0) begin
                errors++;
                $display("FAIL wrap_slice0: got %h want %h", wr_q[0], e0);
            end
            checks++;
            if (wr_q[1] !== e1) begin
                errors++;
                $display("FAIL wrap_slice1: got %h want %h", wr_q[1], e1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        list_mem[0] = mk(9'd100, 6'd0, 9'h040, 3'd3, 8'h05, 1'b0, 4'd1, 2'd0);
        list_mem[1] = mk(9'd200, 6'd0, 9'h050, 3'd0, 8'h81, 1'b0, 4'd7, 2'd1);
        obj_base_addr = 15'h1000;
        ack_wait = 1;
        clear_logs();
        fork
            run_fetch(2, cyc);
            begin
                repeat (6) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        checks++;
        if (wr_q.size() !== 3 || tile_count !== 6'd3 || done_cnt !== 1) begin
            errors++;
            $display("FAIL b2b_count: got wr=%0d cnt=%0d done=%0d want 3 3 1",
                     wr_q.size(), tile_count, done_cnt);
        end else begin
            checks++;
            if (wr_q[0].x !== 9'd100 || wr_q[1].x !== 9'd116 ||
                wr_q[2].x !== 9'd200) begin
                errors++;
                $display("FAIL b2b_x: got %0d %0d %0d want 100 116 200",
                         wr_q[0].x, wr_q[1].x, wr_q[2].x);
            end
            checks++;
            if (wa_q[2] !== 6'd2 || wr_q[2].palette !== 4'd7 ||
                wr_q[1].palette !== 4'd1) begin
                errors++;
                $display("FAIL b2b_attr: got slot=%0d pal=%0d,%0d want 2 1,7",
                         wa_q[2], wr_q[1].palette, wr_q[2].palette);
            end
        end
    endtask

    task automatic test_time_over();
        int cyc;
        int bad;
        for (int i = 0; i < 5; i++)
            list_mem[i] = mk(9'(i * 16), 6'd0, 9'(i * 16), 3'd7, 8'hFF,
                             1'b0, 4'd2, 2'd0);
        obj_base_addr = 15'h0000;
        ack_wait = 1;
        clear_logs();
        run_fetch(5, cyc);
        checks++;
        if (wr_q.size() !== 34 || tile_count !== 6'd34) begin
            errors++;
            $display("FAIL tover_count: got wr=%0d cnt=%0d want 34 34",
                     wr_q.size(), tile_count);
        end
        checks++;
        if (time_over !== 1'b1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL tover_flag: got to=%b done=%0d want 1 1",
                     time_over, done_cnt);
        end
        bad = 0;
        foreach (wa_q[i]) if (wa_q[i] !== 6'(i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL tover_slots: got %0d out-of-order/overflow slots want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int n;
        list_mem[0] = mk(9'd10, 6'd9, 9'h012, 3'd1, 8'h03, 1'b0, 4'd5, 2'd2);
        obj_base_addr = 15'h4000;
        ack_wait = 20;
        clear_logs();
        @(negedge clk);
        num_objs = 6'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(vram_req && vram_addr == 15'h4229) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(vram_req && vram_addr == 15'h4229)) begin
            errors++;
            $display("FAIL rmid_reach_hi: got req=%b addr=%h want 1 4229",
                     vram_req, vram_addr);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({vram_req, busy, tile_we, done} !== 4'b0) begin
            errors++;
            $display("FAIL rmid_abort: got req=%b busy=%b we=%b done=%b want 0",
                     vram_req, busy, tile_we, done);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt !== 0 || wr_q.size() !== 0) begin
            errors++;
            $display("FAIL rmid_nodone: got done=%0d wr=%0d want 0 0",
                     done_cnt, wr_q.size());
        end
        ack_wait = 2;
        clear_logs();
        run_fetch(1, cyc);
        checks++;
        if (tile_count !== 6'd2 || wr_q.size() !== 2 || aa_q.size() !== 4 ||
            (aa_q.size() == 4 && aa_q[0] !== 15'h4221)) begin
            errors++;
            $display("FAIL rmid_refetch: got cnt=%0d wr=%0d req=%0d want 2 2 4",
                     tile_count, wr_q.size(), aa_q.size());
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        num_objs      = '0;
        obj_base_addr = '0;
        ack_wait      = 2;
        req_seen      = 0;
        done_cnt      = 0;
        for (int i = 0; i < 32; i++) list_mem[i] = '0;
        test_reset();
        test_empty();
        test_single();
        test_flip();
        test_wrap();
        test_back_to_back();
        test_time_over();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
